// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x3 matrix keypad scan, frame debounce and one-shot key events.
// Revision : 1.0
// ============================================================================
module keypad_scanner #(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] key,
  output logic       shift,
  output logic       alarm_btn,
  output logic       time_btn
);

  localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DEBOUNCE);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  localparam logic [3:0] c_STAR = 4'hA;
  localparam logic [3:0] c_HASH = 4'hB;
  localparam logic [3:0] c_NONE = 4'hF;

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_DEBOUNCE = 2'd1;
  localparam logic [1:0] c_HELD     = 2'd2;
  localparam logic [1:0] c_RELEASE  = 2'd3;

  logic [c_DIV_W-1:0] r_div;
  logic [1:0]         r_row;
  logic [1:0]         r_hits;
  logic [3:0]         r_fcode;
  logic [1:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic [3:0]         r_code;

  logic               w_sample;
  logic               w_frame_end;
  logic [1:0]         w_row_hits;
  logic [1:0]         w_col;
  logic [3:0]         w_row_code;
  logic [2:0]         w_tot;
  logic [3:0]         w_result;
  logic [c_CNT_W-1:0] w_cnt_inc;
  logic [1:0]         w_state_nxt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [3:0]         w_code_nxt;
  logic               w_fire;
  logic               w_shift_nxt;
  logic               w_alarm_nxt;
  logic               w_time_nxt;

  assign w_sample    = (r_div == c_DIV_LAST);
  assign w_frame_end = w_sample && (r_row == 2'd3);
  assign row_out     = 4'b0001 << r_row;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_div <= '0;
      r_row <= 2'd0;
    end else if (w_sample) begin
      r_div <= '0;
      r_row <= r_row + 2'd1;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
    end
  end

  // Key code of the current row; only meaningful when exactly one column is set.
  always_comb begin
    w_row_hits = {1'b0, col_in[0]} + {1'b0, col_in[1]} + {1'b0, col_in[2]};
    w_col      = col_in[0] ? 2'd0 : (col_in[1] ? 2'd1 : 2'd2);
    if (r_row == 2'd3) begin
      w_row_code = (w_col == 2'd0) ? c_STAR : ((w_col == 2'd1) ? 4'd0 : c_HASH);
    end else begin
      w_row_code = {2'b00, r_row} * 4'd3 + {2'b00, w_col} + 4'd1;
    end
    w_tot    = {1'b0, r_hits} + {1'b0, w_row_hits};
    w_result = c_NONE;
    if (w_tot == 3'd1) begin
      w_result = (r_hits == 2'd1) ? r_fcode : w_row_code;
    end
  end

  // Hit count saturates at 2: any frame with two or more keys is rejected.
  always_ff @(posedge clk) begin
    if (reset || w_frame_end) begin
      r_hits  <= 2'd0;
      r_fcode <= c_NONE;
    end else if (w_sample) begin
      r_hits  <= (w_tot > 3'd2) ? 2'd2 : w_tot[1:0];
      r_fcode <= w_result;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_cnt     <= '0;
      r_code    <= c_NONE;
      key       <= 4'd0;
      shift     <= 1'b0;
      alarm_btn <= 1'b0;
      time_btn  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_code    <= w_code_nxt;
      shift     <= w_shift_nxt;
      alarm_btn <= w_alarm_nxt;
      time_btn  <= w_time_nxt;
      if (w_shift_nxt) begin
        key <= w_code_nxt;
      end
    end
  end

  assign w_cnt_inc = r_cnt + c_CNT_ONE;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_code_nxt  = r_code;
    w_fire      = 1'b0;
    if (w_frame_end) begin
      case (r_state)
        c_IDLE: begin
          if (w_result != c_NONE) begin
            w_code_nxt = w_result;
            w_cnt_nxt  = c_CNT_ONE;
            if (DEBOUNCE == 1) begin
              w_fire      = 1'b1;
              w_state_nxt = c_HELD;
            end else begin
              w_state_nxt = c_DEBOUNCE;
            end
          end
        end
        c_DEBOUNCE: begin
          if (w_result == r_code) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == c_CNT_MAX) begin
              w_fire      = 1'b1;
              w_state_nxt = c_HELD;
            end
          end else begin
            w_state_nxt = c_IDLE;
          end
        end
        c_HELD: begin
          if (w_result != r_code) begin
            w_cnt_nxt   = c_CNT_ONE;
            w_state_nxt = (DEBOUNCE == 1 && w_result == c_NONE) ? c_IDLE : c_RELEASE;
          end
        end
        default: begin
          if (w_result == c_NONE) begin
            w_cnt_nxt = w_cnt_inc;
            if (DEBOUNCE == 1 || w_cnt_inc == c_CNT_MAX) begin
              w_state_nxt = c_IDLE;
            end
          end else begin
            w_cnt_nxt = c_CNT_ONE;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_shift_nxt = w_fire && (w_code_nxt <= 4'd9);
    w_alarm_nxt = w_fire && (w_code_nxt == c_STAR);
    w_time_nxt  = w_fire && (w_code_nxt == c_HASH);
  end

endmodule
`default_nettype wire
